// File: rtl/la_select_sequencer_if.sv
// Management Wishbone slave bundle for the LA select sequencer.
//   wbs_stb_i/wbs_cyc_i : strobe / cycle
//   wbs_we_i            : write enable
//   wbs_sel_i[3:0]      : byte enables
//   wbs_dat_i[31:0]     : write data
//   wbs_adr_i[31:0]     : byte address
//   wbs_ack_o           : acknowledge (registered, one cycle)
//   wbs_dat_o[31:0]     : read data, valid with ack, zero otherwise
interface la_select_sequencer_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_adr_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    output wbs_ack_o, wbs_dat_o
  );

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    input  wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/la_select_sequencer.sv
// Chooses which design slot (0..NUM_TEAMS) drives the logic-analyzer bus.
// Every slot change is bracketed by a blanking window so the LA mux never
// passes partial data; an optional auto-scan steps through the slots.
//   wb_clk_i   : clock
//   wb_rst_i   : synchronous active-high reset
//   wb         : Wishbone slave (CTRL, SEL, BLANK, DWELL, STATUS registers)
//   mux_sel    : active slot index to the LA mux
//   la_blank   : 1 = LA mux output forced to zero
//   busy       : slot switch in progress
//   irq        : level interrupt, DONE & IRQ_EN
module la_select_sequencer #(
  parameter int unsigned NUM_TEAMS = 12,
  parameter int unsigned SEL_W     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  la_select_sequencer_if.slave wb,
  output logic [SEL_W-1:0]     mux_sel,
  output logic                 la_blank,
  output logic                 busy,
  output logic                 irq
);

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned BLANK_W = 8;
  localparam int unsigned DWELL_W = 24;
  localparam int unsigned DWELL_BYTES = DWELL_W / 8;

  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_SEL    = 3'd1;
  localparam logic [2:0] OFF_BLANK  = 3'd2;
  localparam logic [2:0] OFF_DWELL  = 3'd3;
  localparam logic [2:0] OFF_STATUS = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BLANK  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  state_t              state;
  logic                auto_en;
  logic                irq_en;
  logic [BLANK_W-1:0]  blank_cfg;
  logic [DWELL_W-1:0]  dwell_cfg;
  logic                done;
  logic                err;
  logic [SEL_W-1:0]    target;
  logic [BLANK_W-1:0]  cnt;
  logic [DWELL_W-1:0]  dwell_cnt;
  logic                req_pend;
  logic                ack_q;
  logic [DATA_W-1:0]   rdata_q;

  // Address decode; a transfer is accepted only when no ack is outstanding
  logic       hit_c;
  logic       acc_c;
  logic       wr_c;
  logic [2:0] off_c;

  assign hit_c = wb.wbs_stb_i & wb.wbs_cyc_i &
                 (wb.wbs_adr_i[31:5] == BASE_ADDR[31:5]);
  assign acc_c = hit_c & ~ack_q;
  assign wr_c  = acc_c & wb.wbs_we_i;
  assign off_c = wb.wbs_adr_i[4:2];

  // SEL write qualification and STATUS write-one-to-clear strobes
  logic             sel_wr_c;
  logic             sel_ok_c;
  logic [SEL_W-1:0] sel_val_c;
  logic             stat_wr_c;
  logic             clr_done_c;
  logic             clr_err_c;

  assign sel_wr_c   = wr_c & (off_c == OFF_SEL) & wb.wbs_sel_i[0];
  assign sel_val_c  = wb.wbs_dat_i[SEL_W-1:0];
  assign sel_ok_c   = sel_wr_c & (32'(sel_val_c) <= NUM_TEAMS);
  assign stat_wr_c  = wr_c & (off_c == OFF_STATUS) & wb.wbs_sel_i[0];
  assign clr_done_c = stat_wr_c & wb.wbs_dat_i[1];
  assign clr_err_c  = stat_wr_c & wb.wbs_dat_i[2];

  // Auto-scan request: fires on the last cycle of a dwell period in IDLE
  logic             scan_on_c;
  logic             auto_req_c;
  logic [SEL_W-1:0] next_slot_c;

  assign scan_on_c   = auto_en & (dwell_cfg != '0);
  assign auto_req_c  = (state == ST_IDLE) & scan_on_c & ~sel_wr_c &
                       (dwell_cnt == dwell_cfg - DWELL_W'(1));
  assign next_slot_c = (32'(mux_sel) >= NUM_TEAMS) ? '0 : mux_sel + SEL_W'(1);

  // Request arbitration in IDLE: fresh manual write, then a write that
  // landed during COMMIT, then auto-scan
  logic             req_c;
  logic [SEL_W-1:0] req_tgt_c;

  always_comb begin
    req_c     = 1'b0;
    req_tgt_c = target;
    if (sel_ok_c) begin
      req_c     = 1'b1;
      req_tgt_c = sel_val_c;
    end else if (req_pend) begin
      req_c     = 1'b1;
      req_tgt_c = target;
    end else if (auto_req_c) begin
      req_c     = 1'b1;
      req_tgt_c = next_slot_c;
    end
  end

  // Read data mux
  logic [DATA_W-1:0] rd_c;

  always_comb begin
    rd_c = '0;
    case (off_c)
      OFF_CTRL:   rd_c = {30'd0, irq_en, auto_en};
      OFF_SEL:    rd_c = DATA_W'(mux_sel);
      OFF_BLANK:  rd_c = DATA_W'(blank_cfg);
      OFF_DWELL:  rd_c = DATA_W'(dwell_cfg);
      OFF_STATUS: begin
        rd_c[0]          = busy;
        rd_c[1]          = done;
        rd_c[2]          = err;
        rd_c[8 +: SEL_W] = target;
      end
      default:    rd_c = '0;
    endcase
  end

  // Bus handshake and configuration registers
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q     <= 1'b0;
      rdata_q   <= '0;
      auto_en   <= 1'b0;
      irq_en    <= 1'b0;
      blank_cfg <= '0;
      dwell_cfg <= '0;
    end else begin
      ack_q   <= acc_c;
      rdata_q <= acc_c ? rd_c : '0;
      if (wr_c) begin
        case (off_c)
          OFF_CTRL: begin
            if (wb.wbs_sel_i[0]) begin
              auto_en <= wb.wbs_dat_i[0];
              irq_en  <= wb.wbs_dat_i[1];
            end
          end
          OFF_BLANK: begin
            if (wb.wbs_sel_i[0]) blank_cfg <= wb.wbs_dat_i[BLANK_W-1:0];
          end
          OFF_DWELL: begin
            for (int b = 0; b < DWELL_BYTES; b++) begin
              if (wb.wbs_sel_i[b]) dwell_cfg[8*b +: 8] <= wb.wbs_dat_i[8*b +: 8];
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Switch sequencer, dwell timer and sticky status
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= ST_IDLE;
      mux_sel   <= '0;
      la_blank  <= 1'b0;
      busy      <= 1'b0;
      target    <= '0;
      cnt       <= '0;
      dwell_cnt <= '0;
      req_pend  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      // Clears come first so a same-cycle set below wins
      if (clr_done_c) done <= 1'b0;
      if (clr_err_c)  err  <= 1'b0;
      if (sel_wr_c && !sel_ok_c) err <= 1'b1;

      case (state)
        ST_IDLE: begin
          la_blank <= 1'b0;
          busy     <= 1'b0;
          req_pend <= 1'b0;
          if (sel_wr_c || !scan_on_c || auto_req_c) dwell_cnt <= '0;
          else dwell_cnt <= dwell_cnt + DWELL_W'(1);
          if (req_c) begin
            target <= req_tgt_c;
            if (req_tgt_c != mux_sel) begin
              state     <= ST_BLANK;
              cnt       <= blank_cfg;
              la_blank  <= 1'b1;
              busy      <= 1'b1;
              dwell_cnt <= '0;
            end
          end
        end

        ST_BLANK: begin
          dwell_cnt <= '0;
          if (sel_ok_c) target <= sel_val_c;
          if (cnt == '0) begin
            // New slot becomes visible during the final blanked cycle
            state   <= ST_COMMIT;
            mux_sel <= sel_ok_c ? sel_val_c : target;
            done    <= 1'b1;
          end else begin
            cnt <= cnt - BLANK_W'(1);
          end
        end

        ST_COMMIT: begin
          dwell_cnt <= '0;
          state     <= ST_IDLE;
          la_blank  <= 1'b0;
          busy      <= 1'b0;
          // A write arriving now is replayed as a request once back in IDLE
          if (sel_ok_c) begin
            target   <= sel_val_c;
            req_pend <= 1'b1;
          end
        end

        default: begin
          state    <= ST_IDLE;
          la_blank <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

  assign irq          = done & irq_en;
  assign wb.wbs_ack_o = ack_q;
  assign wb.wbs_dat_o = rdata_q;

  // Address bits below word granularity and unused data/byte lanes
  logic unused_c;
  assign unused_c = ^{wb.wbs_adr_i[1:0], wb.wbs_sel_i[3], wb.wbs_dat_i[31:24]};

endmodule

// File: tb/tb_la_select_sequencer.sv
// Bench for la_select_sequencer: directed register/switch scenarios plus
// randomized slot requests and byte-lane writes, checked against a
// slot-level model of the blanking rules.
`timescale 1ns/1ps
module tb_la_select_sequencer;
  localparam int unsigned NUM_TEAMS = 12;
  localparam int unsigned SEL_W     = 4;
  localparam logic [31:0] BASE      = 32'h3000_0000;

  localparam logic [31:0] A_CTRL   = BASE + 32'h00;
  localparam logic [31:0] A_SEL    = BASE + 32'h04;
  localparam logic [31:0] A_BLANK  = BASE + 32'h08;
  localparam logic [31:0] A_DWELL  = BASE + 32'h0C;
  localparam logic [31:0] A_STATUS = BASE + 32'h10;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [SEL_W-1:0] mux_sel;
  logic             la_blank;
  logic             busy;
  logic             irq;

  la_select_sequencer_if bus();

  la_select_sequencer #(
    .NUM_TEAMS(NUM_TEAMS),
    .SEL_W    (SEL_W),
    .BASE_ADDR(BASE)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .wb      (bus.slave),
    .mux_sel (mux_sel),
    .la_blank(la_blank),
    .busy    (busy),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Blank-window monitor: per window, its length, the 1-based blanked cycle
  // in which mux_sel changed, the slot afterwards and the idle gap before it
  int win_len[$];
  int win_chg[$];
  int win_sel[$];
  int win_gap[$];
  int busy_mis = 0;
  int run = 0;
  int chg = 0;
  int gap = 0;
  logic [SEL_W-1:0] prev_sel = '0;

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (la_blank === 1'b1) begin
        if (run == 0) chg = 0;
        run++;
        if (mux_sel !== prev_sel && chg == 0) chg = run;
      end else begin
        if (run > 0) begin
          win_len.push_back(run);
          win_chg.push_back(chg);
          win_sel.push_back(int'(mux_sel));
          win_gap.push_back(gap);
          gap = 0;
        end
        run = 0;
        gap++;
      end
      if (busy !== la_blank) busy_mis++;
      prev_sel = mux_sel;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_windows();
    win_len.delete();
    win_chg.delete();
    win_sel.delete();
    win_gap.delete();
  endtask

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  // One Wishbone transfer, started and finished at a falling edge
  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] d,
                         input logic [3:0] be, output logic [31:0] rd);
    int n = 0;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_we_i  = we;
    bus.wbs_adr_i = adr;
    bus.wbs_sel_i = be;
    bus.wbs_dat_i = d;
    do begin
      @(negedge clk);
      n++;
    end while (bus.wbs_ack_o !== 1'b1 && n < 16);
    check("ack_seen", {31'd0, bus.wbs_ack_o}, 32'd1);
    rd = bus.wbs_dat_o;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] d);
    logic [31:0] dummy;
    wb_xfer(1'b1, adr, d, 4'hF, dummy);
  endtask

  task automatic rd_check(input string tag, input logic [31:0] adr, input logic [31:0] exp);
    logic [31:0] v;
    wb_xfer(1'b0, adr, 32'd0, 4'hF, v);
    check(tag, v, exp);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
  endtask

  // Slot-level reference state
  int unsigned m_sel;
  int unsigned m_tgt;
  int unsigned m_blank;
  logic [23:0] m_dwell;

  initial begin : stim
    int acks;
    int v;
    int exp_win;
    logic exp_done;
    logic exp_err;
    logic [31:0] d;
    logic [3:0]  be;
    logic [31:0] rdv;
    logic stayed;

    bus.wbs_stb_i = 1'b0;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = 4'h0;
    bus.wbs_dat_i = 32'd0;
    bus.wbs_adr_i = 32'd0;

    // 1. Reset state, register reads, ack shape, non-hits
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mux_sel", 32'(mux_sel), 32'd0);
    check("rst_la_blank", {31'd0, la_blank}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_ack", {31'd0, bus.wbs_ack_o}, 32'd0);
    check("rst_dat", bus.wbs_dat_o, 32'd0);
    rd_check("rd_ctrl", A_CTRL, 32'd0);
    @(negedge clk);
    check("ack_one_cycle", {31'd0, bus.wbs_ack_o}, 32'd0);
    check("dat_zero_no_ack", bus.wbs_dat_o, 32'd0);
    rd_check("rd_sel", A_SEL, 32'd0);
    rd_check("rd_blank", A_BLANK, 32'd0);
    rd_check("rd_dwell", A_DWELL, 32'd0);
    rd_check("rd_status", A_STATUS, 32'd0);
    wr(BASE + 32'h14, 32'hFFFF_FFFF);
    rd_check("rd_unmapped14", BASE + 32'h14, 32'd0);
    rd_check("rd_unmapped1c", BASE + 32'h1C, 32'd0);

    // Held strobe: one ack per two cycles
    acks = 0;
    bus.wbs_stb_i = 1'b1; bus.wbs_cyc_i = 1'b1; bus.wbs_we_i = 1'b0;
    bus.wbs_adr_i = A_CTRL; bus.wbs_sel_i = 4'hF;
    repeat (6) begin
      @(negedge clk);
      if (bus.wbs_ack_o === 1'b1) acks++;
    end
    bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0;
    check("held_stb_acks", 32'(acks), 32'd3);

    // Address outside the 32-byte window is never acked
    acks = 0;
    bus.wbs_stb_i = 1'b1; bus.wbs_cyc_i = 1'b1; bus.wbs_adr_i = BASE + 32'h20;
    repeat (4) begin
      @(negedge clk);
      if (bus.wbs_ack_o === 1'b1) acks++;
    end
    bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0;
    check("nonhit_acks", 32'(acks), 32'd0);
    @(negedge clk);

    // 2. BLANK=3 switch to slot 5 with IRQ enabled
    wr(A_BLANK, 32'd3);
    wr(A_CTRL, 32'd2);
    clear_windows();
    wr(A_SEL, 32'd5);
    wait_idle();
    check("t2_windows", 32'(win_len.size()), 32'd1);
    check("t2_blank_len", 32'(qget(win_len, 0)), 32'd5);
    check("t2_sel_change_at", 32'(qget(win_chg, 0)), 32'd5);
    check("t2_mux_sel", 32'(mux_sel), 32'd5);
    check("t2_irq", {31'd0, irq}, 32'd1);
    rd_check("t2_status", A_STATUS, 32'h502);
    wr(A_STATUS, 32'h2);
    check("t2_irq_cleared", {31'd0, irq}, 32'd0);
    rd_check("t2_status_cleared", A_STATUS, 32'h500);

    // 3. Out-of-range slot, then same-slot request
    clear_windows();
    wr(A_SEL, 32'd13);
    wait_idle();
    check("t3_err_windows", 32'(win_len.size()), 32'd0);
    check("t3_err_mux_sel", 32'(mux_sel), 32'd5);
    rd_check("t3_status_err", A_STATUS, 32'h504);
    wr(A_STATUS, 32'h4);
    wr(A_SEL, 32'd5);
    wait_idle();
    check("t3_same_windows", 32'(win_len.size()), 32'd0);
    rd_check("t3_status_same", A_STATUS, 32'h500);

    // 4. Retarget during a long blank window
    wr(A_BLANK, 32'd10);
    clear_windows();
    wr(A_SEL, 32'd2);
    @(negedge clk);
    wr(A_SEL, 32'd7);
    wait_idle();
    check("t4_windows", 32'(win_len.size()), 32'd1);
    check("t4_blank_len", 32'(qget(win_len, 0)), 32'd12);
    check("t4_final_sel", 32'(qget(win_sel, 0)), 32'd7);
    check("t4_sel_change_at", 32'(qget(win_chg, 0)), 32'd12);

    // Randomized requests against the slot model
    m_sel = 7;
    m_tgt = 7;
    for (int i = 0; i < 14; i++) begin
      m_blank = $urandom_range(0, 5);
      wr(A_BLANK, m_blank);
      wr(A_STATUS, 32'h6);
      v = (i == 3) ? int'(m_sel) : int'($urandom_range(0, 15));
      clear_windows();
      wr(A_SEL, 32'(v));
      wait_idle();
      exp_err  = (v > int'(NUM_TEAMS));
      exp_done = !exp_err && (v != int'(m_sel));
      exp_win  = exp_done ? 1 : 0;
      if (!exp_err) m_tgt = v;
      if (exp_done) m_sel = v;
      check("rnd_windows", 32'(win_len.size()), 32'(exp_win));
      check("rnd_mux_sel", 32'(mux_sel), m_sel);
      check("rnd_irq", {31'd0, irq}, {31'd0, exp_done});
      rd_check("rnd_status", A_STATUS, (m_tgt << 8) | (32'(exp_err) << 2) | (32'(exp_done) << 1));
      if (exp_win == 1) begin
        check("rnd_blank_len", 32'(qget(win_len, 0)), m_blank + 2);
        check("rnd_sel_change_at", 32'(qget(win_chg, 0)), m_blank + 2);
      end
    end

    // Randomized byte-lane writes to DWELL (auto-scan stays off)
    wr(A_DWELL, 32'd0);
    m_dwell = '0;
    for (int i = 0; i < 6; i++) begin
      d  = $urandom;
      be = 4'($urandom_range(0, 15));
      wb_xfer(1'b1, A_DWELL, d, be, rdv);
      for (int b = 0; b < 3; b++) begin
        if (be[b]) m_dwell[8*b +: 8] = d[8*b +: 8];
      end
      rd_check("lane_dwell", A_DWELL, {8'd0, m_dwell});
    end
    wr(A_BLANK, 32'd9);
    wb_xfer(1'b1, A_BLANK, 32'd44, 4'hE, rdv);
    rd_check("lane_blank_masked", A_BLANK, 32'd9);

    // 5. Auto-scan from slot 11, DWELL=4, BLANK=0
    wr(A_BLANK, 32'd0);
    wr(A_SEL, 32'd11);
    wait_idle();
    wr(A_DWELL, 32'd4);
    clear_windows();
    wr(A_CTRL, 32'd3);
    v = 0;
    while (win_len.size() < 3 && v < 200) begin
      @(negedge clk);
      v++;
    end
    wr(A_CTRL, 32'd2);
    wait_idle();
    repeat (8) @(negedge clk);
    check("t5_windows", 32'(win_len.size()), 32'd3);
    check("t5_sel0", 32'(qget(win_sel, 0)), 32'd12);
    check("t5_sel1", 32'(qget(win_sel, 1)), 32'd0);
    check("t5_sel2", 32'(qget(win_sel, 2)), 32'd1);
    check("t5_len0", 32'(qget(win_len, 0)), 32'd2);
    check("t5_len1", 32'(qget(win_len, 1)), 32'd2);
    check("t5_len2", 32'(qget(win_len, 2)), 32'd2);
    check("t5_gap1", 32'(qget(win_gap, 1)), 32'd4);
    check("t5_gap2", 32'(qget(win_gap, 2)), 32'd4);

    // 6. Reset in the middle of a blank window
    wr(A_BLANK, 32'd20);
    wr(A_SEL, 32'd9);
    repeat (4) @(negedge clk);
    check("t6_blank_before_rst", {31'd0, la_blank}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_mux_sel", 32'(mux_sel), 32'd0);
    check("t6_la_blank", {31'd0, la_blank}, 32'd0);
    check("t6_busy", {31'd0, busy}, 32'd0);
    check("t6_irq", {31'd0, irq}, 32'd0);
    stayed = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (la_blank !== 1'b0 || mux_sel !== '0 || irq !== 1'b0) stayed = 1'b0;
    end
    check("t6_stays_idle", {31'd0, stayed}, 32'd1);
    rd_check("t6_status", A_STATUS, 32'd0);
    rd_check("t6_blank", A_BLANK, 32'd0);
    rd_check("t6_ctrl", A_CTRL, 32'd0);

    check("busy_tracks_blank", 32'(busy_mis), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/la_select_sequencer.md
Name: la_select_sequencer

Overview:
Wishbone-programmable controller that decides which design slot (0..NUM_TEAMS) drives the 128-bit logic-analyzer bus. It produces the select index for the LA output multiplexer and a blanking strobe that forces the LA bus to zero while the select changes, so no partial or glitched design data reaches the LA. It also has an optional auto-scan mode that steps through the slots on a programmable dwell period. It sits beside the LA mux on the management Wishbone bus.

Parameters:
NUM_TEAMS, 12, highest valid slot index; valid slots are 0..NUM_TEAMS.
SEL_W, 4, width of the select index; must satisfy 2^SEL_W > NUM_TEAMS.
BASE_ADDR, 32'h3000_0000, block base address; 32-byte aligned.

Ports:
wb_clk_i  in  1  sole clock
wb_rst_i  in  1  reset, synchronous, active-high
wbs_stb_i  in  1  WB strobe
wbs_cyc_i  in  1  WB cycle
wbs_we_i  in  1  WB write enable
wbs_sel_i  in  4  WB byte enables
wbs_dat_i  in  32  WB write data
wbs_adr_i  in  32  WB byte address
wbs_ack_o  out  1  WB acknowledge
wbs_dat_o  out  32  WB read data
mux_sel  out  SEL_W  active slot index to the LA mux
la_blank  out  1  1 = LA mux output forced to zero
busy  out  1  switch in progress
irq  out  1  level interrupt, switch completed

Behaviour:
- Reset (one clock with wb_rst_i=1) clears every register and output to 0: mux_sel, la_blank, busy, irq, wbs_ack_o, wbs_dat_o, all config registers and counters. FSM returns to IDLE. Reset during BLANK aborts the switch; mux_sel=0 from the next cycle.
- Decode: a hit requires wbs_adr_i[31:5]==BASE_ADDR[31:5] and stb&cyc. Offset = wbs_adr_i[4:2].
- Non-hits get no ack. Hits on unmapped offsets are acked; they read 0 and writes to them are ignored.
- Handshake: wbs_ack_o is a registered 1-cycle pulse, asserted the cycle after a hit is seen. It is forced low in the cycle following an ack, so a held strobe yields one ack per two cycles. wbs_dat_o is valid with ack and is 0 otherwise. The write takes effect on the ack edge.
- Byte lanes: writes honour wbs_sel_i per byte.
- Registers:
  - 0x00 CTRL: [0] AUTO_EN, [1] IRQ_EN. R/W.
  - 0x04 SEL: write [SEL_W-1:0] = requested slot, takes effect only if wbs_sel_i[0]. Read returns the current mux_sel.
  - 0x08 BLANK: [7:0] number of extra blank cycles. R/W.
  - 0x0C DWELL: [23:0] auto-scan period in cycles; 0 disables stepping. R/W.
  - 0x10 STATUS: [0] busy (RO), [1] DONE (sticky, write 1 to clear), [2] ERR (sticky, write 1 to clear), [8+SEL_W-1:8] pending target (RO).
- SEL write value > NUM_TEAMS: ignored, sets ERR, no FSM effect.
- FSM states:
  - IDLE: la_blank=0, busy=0. A request whose target differs from mux_sel moves to BLANK and loads cnt=BLANK. A request equal to mux_sel is a no-op (DONE not set).
  - BLANK: la_blank=1, busy=1. cnt decrements each cycle; at cnt==0 go to COMMIT.
  - COMMIT (1 cycle): la_blank=1, busy=1, mux_sel<=target, DONE<=1, then go to IDLE.
- Switch latency: request accepted at cycle t. la_blank is high for cycles t+1 .. t+BLANK+2. The new mux_sel is visible from cycle t+BLANK+2, while still blanked.
- A SEL write during BLANK/COMMIT updates target (latest valid write wins) and does not restart cnt. A write landing in the COMMIT cycle becomes a new request in IDLE.
- Auto-scan (AUTO_EN=1, DWELL!=0):
  - dwell counter increments only in IDLE.
  - When it equals DWELL-1, it clears and issues a request with target = mux_sel+1, wrapping NUM_TEAMS -> 0.
  - The counter is held at 0 when AUTO_EN=0, DWELL=0, or in BLANK/COMMIT.
  - A manual SEL write clears the dwell counter and takes priority over an auto request in the same cycle.
- irq = DONE & IRQ_EN, combinational from registers. Clearing DONE drops irq the next cycle. If a set and a clear of DONE land in the same cycle, the set wins.

Test Plan:
1. Reset, then read every register -> all 0; mux_sel=0, la_blank=0, irq=0; each ack is exactly 1 cycle wide.
2. BLANK=3, IRQ_EN=1, write SEL=5 -> la_blank high for exactly 5 cycles, mux_sel=5 from the 5th blanked cycle, DONE=1, irq=1. Write STATUS=0x2 -> irq=0.
3. Write SEL=13 with NUM_TEAMS=12 -> ERR=1, mux_sel unchanged, busy never set. Write SEL equal to the current slot -> no blanking, DONE stays 0.
4. BLANK=10, write SEL=2 then SEL=7 two cycles later -> single blank window of 12 cycles, final mux_sel=7.
5. Start at mux_sel=11, AUTO_EN=1, DWELL=4, BLANK=0 -> sequence 12, 0, 1 with 4 idle cycles between switches and 2 blanked cycles per switch.
6. Assert wb_rst_i mid-BLANK -> next cycle mux_sel=0, la_blank=0, busy=0; FSM in IDLE; no irq.
